// File: rtl/xbox_apb_csr.sv
`default_nettype none
// ============================================================================
// Module   : xbox_apb_csr
// Brief    : APB slave exposing 32 x 32-bit host registers. Each register has
//            a one-cycle write strobe and an optional accelerator readback path.
//            Optional macro XBOX_CSR_PSLVERR_EN enables error responses for
//            misaligned or out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module xbox_apb_csr #(
  parameter int WAIT_STATES = 0,
  parameter int APB_ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [APB_ADDR_W-1:0]  paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [31:0][31:0]      host_regs,
  output logic [31:0]            host_regs_valid_pulse,
  input  logic [31:0][31:0]      host_regs_data_out,
  input  logic [31:0]            host_regs_valid_out
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [4:0] C_WAIT = 5'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [4:0]        wcnt_q, wcnt_d;
  logic [31:0][31:0] regs_q, regs_d;
  logic [31:0]       pulse_q, pulse_d;

  logic [4:0]  w_idx;
  logic        w_oor;
  logic        w_err;
  logic        w_ready;
  logic        w_commit;
  logic        w_rd_ok;

  assign w_idx = paddr[6:2];

  // Upper address bits beyond the 32-register window mark an out-of-range access.
  generate
    if (APB_ADDR_W > 7) begin : g_oor_chk
      assign w_oor = |paddr[APB_ADDR_W-1:7];
    end else begin : g_oor_none
      assign w_oor = 1'b0;
    end
  endgenerate

  // Completion is suppressed while rst is high so a reset always wins over a commit.
  assign w_ready = (state_q == ACCESS) && psel && penable && (wcnt_q == C_WAIT) && !rst;

`ifdef XBOX_CSR_PSLVERR_EN
  assign w_err = w_ready && ((paddr[1:0] != 2'b00) || w_oor);
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^paddr[1:0];
  assign w_err         = 1'b0;
`endif

  assign w_commit = w_ready && pwrite && !w_err && !w_oor;
  assign w_rd_ok  = w_ready && !pwrite && !w_err && !w_oor;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          wcnt_d  = '0;
        end
      end
      ACCESS: begin
        if (!psel || w_ready) begin
          state_d = IDLE;
        end else if (wcnt_q != C_WAIT) begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (w_commit) begin
      regs_d[w_idx]  = pwdata;
      pulse_d[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (w_rd_ok) begin
      prdata = host_regs_valid_out[w_idx] ? host_regs_data_out[w_idx] : regs_q[w_idx];
    end
  end

  assign pready                = w_ready;
  assign pslverr               = w_err;
  assign host_regs             = regs_q;
  assign host_regs_valid_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_xbox_apb_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbox_apb_csr
// Brief    : Scoreboard bench for xbox_apb_csr. Stimulus queues expected APB
//            responses; a monitor checks them plus write strobes and register
//            contents. Honours XBOX_CSR_PSLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbox_apb_csr;

  localparam int TB_WS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [31:0][31:0] host_regs;
  logic [31:0]       host_regs_valid_pulse;
  logic [31:0][31:0] host_regs_data_out;
  logic [31:0]       host_regs_valid_out;

  xbox_apb_csr #(.WAIT_STATES(TB_WS), .APB_ADDR_W(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .psel                  (psel),
    .penable               (penable),
    .pwrite                (pwrite),
    .paddr                 (paddr),
    .pwdata                (pwdata),
    .prdata                (prdata),
    .pready                (pready),
    .pslverr               (pslverr),
    .host_regs             (host_regs),
    .host_regs_valid_pulse (host_regs_valid_pulse),
    .host_regs_data_out    (host_regs_data_out),
    .host_regs_valid_out   (host_regs_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [31:0] rdata;
    logic        err;
    logic        commit;
    logic [4:0]  idx;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: APB completions against the queue, then strobe/register follow-up.
  int          waits   = 0;
  logic        exp_pls = 1'b0;
  logic [4:0]  pls_idx = '0;
  logic [31:0] pls_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      waits   = 0;
      exp_pls = 1'b0;
    end else begin
      if (exp_pls) begin
        chk("pulse_vec", host_regs_valid_pulse, 32'h1 << pls_idx);
        chk("reg_after_commit", host_regs[pls_idx], pls_dat);
        exp_pls = 1'b0;
      end else if (host_regs_valid_pulse != 32'h0) begin
        chk("unexpected_pulse", host_regs_valid_pulse, 32'h0);
      end
      if (!pready && pslverr) chk("slverr_without_ready", {31'h0, pslverr}, 32'h0);
      if (psel && penable && !pready) begin
        waits++;
      end else if (pready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {31'h0, pready}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wait_cycles", waits, TB_WS);
          chk("pslverr", {31'h0, pslverr}, {31'h0, e.err});
          if (e.rd) chk("prdata", prdata, e.rdata);
          if (e.commit) begin
            exp_pls = 1'b1;
            pls_idx = e.idx;
            pls_dat = e.wdata;
          end
        end
        waits = 0;
      end else begin
        waits = 0;
      end
    end
  end

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input logic exp_commit,
                      input logic rst_in_ready);
    logic got;
    exp_t e;
    e.rd = !wr; e.rdata = exp_rd; e.err = exp_err; e.commit = exp_commit;
    e.idx = addr[6:2]; e.wdata = wd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pready) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 32'h0, 32'h1);
    if (rst_in_ready) begin
      #1 rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    host_regs_data_out = '0; host_regs_valid_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_regs_zero", {31'h0, host_regs == '0}, 32'h1);
    chk("rst_pulse_zero", host_regs_valid_pulse, 32'h0);

    // Basic write and strobe
    xfer(1'b1, 8'h00, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0);

    // Accelerator readback select
    xfer(1'b1, 8'h08, 32'h0000_0055, 32'h0, 1'b0, 1'b1, 1'b0);
    host_regs_data_out[2]  = 32'h0000_0001;
    host_regs_valid_out[2] = 1'b1;
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    host_regs_valid_out[2] = 1'b0;
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0055, 1'b0, 1'b0, 1'b0);

    xfer(1'b1, 8'h04, 32'h0000_00A5, 32'h0, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);

    // Abort: psel dropped in the second access cycle of a write to reg 3
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_reg3", host_regs[3], 32'h0);

    // Access phase without a setup phase is ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nosetup_pready", {31'h0, pready}, 32'h0);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("nosetup_reg4", host_regs[4], 32'h0);

`ifdef XBOX_CSR_PSLVERR_EN
    xfer(1'b1, 8'h03, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h80, 32'h0000_DEAD, 32'h0, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 8'h80, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
`else
    xfer(1'b1, 8'h03, 32'h0000_00FF, 32'h0, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h80, 32'h0000_DEAD, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h80, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
`endif

    // Same register written back-to-back gives two strobes
    xfer(1'b1, 8'h7C, 32'h0000_0011, 32'h0, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 8'h7C, 32'h0000_0022, 32'h0, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 8'h7C, 32'h0, 32'h0000_0022, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("hold_reg31", host_regs[31], 32'h0000_0022);
    chk("hold_reg1", host_regs[1], 32'h0000_00A5);

    // Reset asserted in the completion cycle of a write
    xfer(1'b1, 8'h00, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rstw_pready", {31'h0, pready}, 32'h0);
    chk("rstw_regs_zero", {31'h0, host_regs == '0}, 32'h1);
    chk("rstw_pulse", host_regs_valid_pulse, 32'h0);
    xfer(1'b0, 8'h7C, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
